// File: rtl/mem_stage_hs_pkg.sv
// Shared constants for the MEM stage: branch condition codes and FSM state encoding.
package mem_stage_hs_pkg;

  localparam logic [2:0] BR_NEQ    = 3'b000;
  localparam logic [2:0] BR_EQ     = 3'b001;
  localparam logic [2:0] BR_GT     = 3'b010;
  localparam logic [2:0] BR_LT     = 3'b011;
  localparam logic [2:0] BR_GTE    = 3'b100;
  localparam logic [2:0] BR_LTE    = 3'b101;
  localparam logic [2:0] BR_OVFL   = 3'b110;
  localparam logic [2:0] BR_UNCOND = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_stage_hs_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface mem_stage_hs_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 16
) ();

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_stage_hs_br_resolve.sv
// Pure combinational branch condition evaluator on the EX/MEM flag bits.
module mem_stage_hs_br_resolve
  import mem_stage_hs_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       zr,
  input  logic       ne,
  input  logic       ov,
  output logic       taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (cond)
      BR_NEQ:    taken_c = ~zr;
      BR_EQ:     taken_c = zr;
      BR_GT:     taken_c = ~(zr | ne);
      BR_LT:     taken_c = ne;
      BR_GTE:    taken_c = ~ne;
      BR_LTE:    taken_c = ne | zr;
      BR_OVFL:   taken_c = ov;
      BR_UNCOND: taken_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: req/ack data-memory access with stall and timeout,
// plus branch resolution from the EX/MEM flags.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 16,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   addr_EX_MEM,
  input  logic            re_EX_MEM,
  input  logic            we_EX_MEM,
  input  logic [DW-1:0]   wdata_EX_MEM,
  input  logic            zr_EX_MEM,
  input  logic            ne_EX_MEM,
  input  logic            ov_EX_MEM,
  input  logic            br_valid_EX_MEM,
  input  logic [2:0]      br_cond_EX_MEM,
  input  logic            flush,
  mem_stage_hs_if.master  bus,
  output logic            stall,
  output logic [DW-1:0]   rd_data_MEM,
  output logic            rd_valid_MEM,
  output logic            branch,
  output logic            timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          kill, kill_nxt;
  logic          req_nxt, we_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] wdata_nxt;
  logic [DW-1:0] rd_data_nxt;
  logic          rd_valid_nxt;
  logic          terr_nxt;
  logic          access;
  logic          taken_c;

  assign access = (re_EX_MEM | we_EX_MEM) & ~flush;

  // State and registered-output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      kill            <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      rd_data_MEM     <= '0;
      rd_valid_MEM    <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      kill            <= kill_nxt;
      bus.mem_req_o   <= req_nxt;
      bus.mem_we_o    <= we_nxt;
      bus.mem_addr_o  <= addr_nxt;
      bus.mem_wdata_o <= wdata_nxt;
      rd_data_MEM     <= rd_data_nxt;
      rd_valid_MEM    <= rd_valid_nxt;
      timeout_err     <= terr_nxt;
    end
  end

  // Next-state and next-output logic; a write wins over a simultaneous read
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    kill_nxt     = kill;
    req_nxt      = bus.mem_req_o;
    we_nxt       = bus.mem_we_o;
    addr_nxt     = bus.mem_addr_o;
    wdata_nxt    = bus.mem_wdata_o;
    rd_data_nxt  = rd_data_MEM;
    rd_valid_nxt = 1'b0;
    terr_nxt     = timeout_err;
    stall        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (access) begin
          stall     = 1'b1;
          state_nxt = ST_BUSY;
          req_nxt   = 1'b1;
          we_nxt    = we_EX_MEM;
          addr_nxt  = addr_EX_MEM;
          wdata_nxt = wdata_EX_MEM;
          cnt_nxt   = '0;
          kill_nxt  = 1'b0;
        end
      end
      ST_BUSY: begin
        stall   = 1'b1;
        cnt_nxt = cnt + TW'(1);
        if (flush) kill_nxt = 1'b1;
        if (bus.mem_ack_i) begin
          state_nxt = ST_DONE;
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
          // A flushed read still drains, but its data is dropped
          if (!bus.mem_we_o && !(kill || flush)) begin
            rd_data_nxt  = bus.mem_rdata_i;
            rd_valid_nxt = 1'b1;
          end
        end else if (cnt == TW'(TIMEOUT_CYC - 1)) begin
          state_nxt   = ST_DONE;
          req_nxt     = 1'b0;
          cnt_nxt     = '0;
          terr_nxt    = 1'b1;
          rd_data_nxt = '0;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  mem_stage_hs_br_resolve u_br_resolve (
    .cond    (br_cond_EX_MEM),
    .zr      (zr_EX_MEM),
    .ne      (ne_EX_MEM),
    .ov      (ov_EX_MEM),
    .taken_c (taken_c)
  );

  assign branch = br_valid_EX_MEM & ~flush & taken_c;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed scenarios plus randomized accesses against a
// transaction-level reference model.
module tb_mem_stage_hs;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int          TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr_EX_MEM;
  logic          re_EX_MEM, we_EX_MEM;
  logic [DW-1:0] wdata_EX_MEM;
  logic          zr_EX_MEM, ne_EX_MEM, ov_EX_MEM;
  logic          br_valid_EX_MEM;
  logic [2:0]    br_cond_EX_MEM;
  logic          flush;
  logic          stall;
  logic [DW-1:0] rd_data_MEM;
  logic          rd_valid_MEM;
  logic          branch;
  logic          timeout_err;

  mem_stage_hs_if #(.DW(DW), .AW(AW)) bus ();

  mem_stage_hs #(.DW(DW), .AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .addr_EX_MEM     (addr_EX_MEM),
    .re_EX_MEM       (re_EX_MEM),
    .we_EX_MEM       (we_EX_MEM),
    .wdata_EX_MEM    (wdata_EX_MEM),
    .zr_EX_MEM       (zr_EX_MEM),
    .ne_EX_MEM       (ne_EX_MEM),
    .ov_EX_MEM       (ov_EX_MEM),
    .br_valid_EX_MEM (br_valid_EX_MEM),
    .br_cond_EX_MEM  (br_cond_EX_MEM),
    .flush           (flush),
    .bus             (bus),
    .stall           (stall),
    .rd_data_MEM     (rd_data_MEM),
    .rd_valid_MEM    (rd_valid_MEM),
    .branch          (branch),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stall = 0;
  int n_req   = 0;

  // Reference model state: last visible load data and sticky timeout flag
  logic [DW-1:0] exp_rd;
  logic          exp_terr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic br_model(input logic v, input logic fl, input logic [2:0] c,
                                    input logic z, input logic n, input logic o);
    logic t;
    case (c)
      3'd0:    t = !z;
      3'd1:    t = z;
      3'd2:    t = !z && !n;
      3'd3:    t = n;
      3'd4:    t = !n;
      3'd5:    t = n || z;
      3'd6:    t = o;
      default: t = 1'b1;
    endcase
    return v && !fl && t;
  endfunction

  // One cycle: random branch inputs, check comb/registered handshake outputs, advance
  task automatic cyc(input string tag, input logic exp_stall, input logic exp_req);
    br_valid_EX_MEM = 1'($urandom);
    br_cond_EX_MEM  = 3'($urandom);
    zr_EX_MEM       = 1'($urandom);
    ne_EX_MEM       = 1'($urandom);
    ov_EX_MEM       = 1'($urandom);
    #1;
    chk({tag, ":stall"}, 32'(stall), 32'(exp_stall));
    chk({tag, ":req"}, 32'(bus.mem_req_o), 32'(exp_req));
    chk({tag, ":branch"}, 32'(branch),
        32'(br_model(br_valid_EX_MEM, flush, br_cond_EX_MEM, zr_EX_MEM, ne_EX_MEM, ov_EX_MEM)));
    if (stall === 1'b1) n_stall++;
    if (bus.mem_req_o === 1'b1) n_req++;
    @(negedge clk);
  endtask

  // One complete access; ack_k is the BUSY-cycle index of the ack (>= TO: none),
  // flush_k the BUSY-cycle index of a flush pulse (-1: none)
  task automatic access(input logic re_i, input logic we_i, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] rdata,
                        input int ack_k, input int flush_k, input logic late_ack);
    logic is_wr, acked, killed;
    int   busy_len;
    is_wr    = we_i;
    acked    = (ack_k < TO);
    busy_len = acked ? ack_k + 1 : TO;
    killed   = (flush_k >= 0) && (flush_k < busy_len);
    n_stall  = 0;
    n_req    = 0;

    re_EX_MEM = re_i; we_EX_MEM = we_i; addr_EX_MEM = a; wdata_EX_MEM = d;
    flush = 1'b0; bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 16'($urandom);
    cyc("idle_req", 1'b1, 1'b0);

    for (int k = 0; k < busy_len; k++) begin
      flush = (k == flush_k);
      bus.mem_ack_i   = acked && (k == ack_k);
      bus.mem_rdata_i = (acked && k == ack_k) ? rdata : 16'($urandom);
      chk("busy:we", 32'(bus.mem_we_o), 32'(is_wr));
      chk("busy:addr", 32'(bus.mem_addr_o), 32'(a));
      chk("busy:wdata", 32'(bus.mem_wdata_o), 32'(d));
      cyc("busy", 1'b1, 1'b1);
    end

    if (!acked) begin
      exp_terr = 1'b1;
      exp_rd   = '0;
    end else if (!is_wr && !killed) begin
      exp_rd = rdata;
    end

    re_EX_MEM = 1'($urandom); we_EX_MEM = 1'($urandom);
    flush = 1'($urandom); bus.mem_ack_i = late_ack; bus.mem_rdata_i = 16'($urandom);
    chk("done:rd_valid", 32'(rd_valid_MEM), 32'(acked && !is_wr && !killed));
    chk("done:rd_data", 32'(rd_data_MEM), 32'(exp_rd));
    chk("done:terr", 32'(timeout_err), 32'(exp_terr));
    cyc("done", 1'b0, 1'b0);

    re_EX_MEM = 1'b0; we_EX_MEM = 1'b0; flush = 1'b0;
    chk("idle:rd_valid", 32'(rd_valid_MEM), 32'd0);
    cyc("idle_after", 1'b0, 1'b0);
    bus.mem_ack_i = 1'b0;
    chk("idle:rd_data", 32'(rd_data_MEM), 32'(exp_rd));
    chk("idle:terr", 32'(timeout_err), 32'(exp_terr));
    chk("stall_cycles", 32'(n_stall), 32'(busy_len + 1));
    chk("req_cycles", 32'(n_req), 32'(busy_len));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ":req"}, 32'(bus.mem_req_o), 32'd0);
    chk({tag, ":we"}, 32'(bus.mem_we_o), 32'd0);
    chk({tag, ":addr"}, 32'(bus.mem_addr_o), 32'd0);
    chk({tag, ":wdata"}, 32'(bus.mem_wdata_o), 32'd0);
    chk({tag, ":rd_data"}, 32'(rd_data_MEM), 32'd0);
    chk({tag, ":rd_valid"}, 32'(rd_valid_MEM), 32'd0);
    chk({tag, ":terr"}, 32'(timeout_err), 32'd0);
    chk({tag, ":stall"}, 32'(stall), 32'd0);
    chk({tag, ":branch"}, 32'(branch), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    addr_EX_MEM = '0; re_EX_MEM = 1'b0; we_EX_MEM = 1'b0; wdata_EX_MEM = '0;
    zr_EX_MEM = 1'b0; ne_EX_MEM = 1'b0; ov_EX_MEM = 1'b0;
    br_valid_EX_MEM = 1'b0; br_cond_EX_MEM = 3'd0; flush = 1'b0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    exp_rd = '0; exp_terr = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    cyc("post_reset", 1'b0, 1'b0);

    // Minimum-latency load
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, -1, 1'b0);
    chk("load_beef", 32'(rd_data_MEM), 32'h0000_BEEF);
    // Store acked on the 5th BUSY cycle
    access(1'b0, 1'b1, 16'h0080, 16'h1234, 16'h0000, 4, -1, 1'b0);
    // Read and write both requested: write wins
    access(1'b1, 1'b1, 16'h00C0, 16'hA5A5, 16'h7777, 1, -1, 1'b0);
    // Ack on the very last BUSY cycle beats the timeout
    access(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hCAFE, TO - 1, -1, 1'b0);
    // Timeout on a load, with a late ack that must be ignored
    access(1'b1, 1'b0, 16'h0140, 16'h0000, 16'h5555, TO + 5, -1, 1'b1);
    chk("timeout_rd_zero", 32'(rd_data_MEM), 32'd0);
    // Timeout flag is sticky across a successful load
    access(1'b1, 1'b0, 16'h0180, 16'h0000, 16'h1111, 2, -1, 1'b0);
    chk("terr_sticky", 32'(timeout_err), 32'd1);

    // Flush in IDLE with a store: no access is started
    we_EX_MEM = 1'b1; flush = 1'b1;
    cyc("flush_idle", 1'b0, 1'b0);
    we_EX_MEM = 1'b0; flush = 1'b0;
    cyc("flush_idle_after", 1'b0, 1'b0);
    // Flushed read drains but delivers nothing; flushed write still completes
    access(1'b1, 1'b0, 16'h01C0, 16'h0000, 16'h2222, 3, 1, 1'b0);
    access(1'b1, 1'b0, 16'h01C4, 16'h0000, 16'h3333, 2, 2, 1'b0);
    access(1'b0, 1'b1, 16'h0200, 16'h4444, 16'h0000, 3, 0, 1'b0);

    // Branch condition sweep, state-independent comb path
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [2:0] fl;
        fl = 3'(f);
        br_cond_EX_MEM = 3'(c);
        zr_EX_MEM = fl[0]; ne_EX_MEM = fl[1]; ov_EX_MEM = fl[2];
        br_valid_EX_MEM = 1'b1; flush = 1'b0;
        #1 chk("br_sweep", 32'(branch), 32'(br_model(1'b1, 1'b0, 3'(c), fl[0], fl[1], fl[2])));
        flush = 1'b1;
        #1 chk("br_flush", 32'(branch), 32'd0);
        flush = 1'b0; br_valid_EX_MEM = 1'b0;
        #1 chk("br_invalid", 32'(branch), 32'd0);
      end
    end
    @(negedge clk);

    // Randomized accesses with idle gaps and flushed requests in between
    for (int i = 0; i < 40; i++) begin
      int sel, ack_k, flush_k, busy;
      logic r, w;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        re_EX_MEM = 1'($urandom); we_EX_MEM = 1'($urandom); flush = 1'b1;
        cyc("rnd_gap", 1'b0, 1'b0);
      end
      re_EX_MEM = 1'b0; we_EX_MEM = 1'b0; flush = 1'b0;
      sel = $urandom_range(0, 2);
      r = (sel != 1);
      w = (sel != 0);
      ack_k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 4);
      busy  = (ack_k < TO) ? ack_k + 1 : TO;
      flush_k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, busy - 1) : -1;
      access(r, w, 16'($urandom), 16'($urandom), 16'($urandom), ack_k, flush_k,
             1'($urandom));
    end

    // Reset in the middle of a BUSY access
    re_EX_MEM = 1'b1; addr_EX_MEM = 16'h0300; flush = 1'b0; bus.mem_ack_i = 1'b0;
    cyc("mid_idle", 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc("mid_busy", 1'b1, 1'b1);
    rst_n = 1'b0; re_EX_MEM = 1'b0;
    cyc("mid_rst", 1'b1, 1'b1);
    br_valid_EX_MEM = 1'b0;
    #1 check_reset_state("mid_reset");
    rst_n = 1'b1;
    exp_rd = '0; exp_terr = 1'b0;
    @(negedge clk);
    access(1'b1, 1'b0, 16'h0340, 16'h0000, 16'h9ABC, 1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
